// File: rtl/pipeline_interlock.sv
// Stall/flush/freeze controller for hazards forwarding cannot hide: load-use, taken branches, slow data memory.
// Optional macro PIPELINE_INTERLOCK_PERF_EN adds saturating event counters.
//   state       | meaning
//   ST_RUN      | normal issue; load-use stall or branch flush decided here
//   ST_MEM_WAIT | pipeline frozen on an outstanding data-memory access
//   ST_FLUSH    | remaining wrong-path bubble cycles after a taken branch
module pipeline_interlock #(
    parameter int REG_W        = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rm_id,
    input  logic [REG_W-1:0] Rn_id,
    input  logic             uses_rm_id,
    input  logic             uses_rn_id,
    input  logic [REG_W-1:0] Rd_ex,
    input  logic             write_reg_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic             mem_req_mem,
    input  logic             mem_ready_mem,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_ex,
    output logic             flush_ifid,
    output logic             freeze_all,
    output logic             mem_timeout
`ifdef PIPELINE_INTERLOCK_PERF_EN
   ,output logic [15:0]      load_use_cnt,
    output logic [15:0]      mem_stall_cnt,
    output logic [15:0]      flush_cnt_total
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       resume_q, resume_d;
    logic       timeout_q, timeout_d;

    logic load_use;
    logic mem_stall;
    logic stall_c, bubble_c, flush_c, freeze_c, timeout_fire;

    assign load_use  = mem_read_ex & write_reg_ex &
                       ((uses_rm_id & (Rd_ex == Rm_id)) | (uses_rn_id & (Rd_ex == Rn_id)));
    assign mem_stall = mem_req_mem & ~mem_ready_mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            flush_cnt_q <= 3'd0;
            resume_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            resume_q    <= resume_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        resume_d     = resume_q;
        timeout_d    = timeout_q;
        stall_c      = 1'b0;
        bubble_c     = 1'b0;
        flush_c      = 1'b0;
        freeze_c     = 1'b0;
        timeout_fire = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    freeze_c   = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                    resume_d   = 1'b0;
                end else if (branch_taken_ex) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_ready_mem) begin
                    wait_cnt_d = 8'd0;
                    if (resume_q) begin
                        // Held IF/ID still carries a wrong-path instruction: this cycle is a flush cycle.
                        resume_d    = 1'b0;
                        flush_c     = 1'b1;
                        bubble_c    = 1'b1;
                        flush_cnt_d = flush_cnt_q - 3'd1;
                        state_d     = (flush_cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                        if (branch_taken_ex) begin
                            flush_c  = 1'b1;
                            bubble_c = 1'b1;
                            if (FLUSH_CYCLES > 1) begin
                                state_d     = ST_FLUSH;
                                flush_cnt_d = FLUSH_INIT;
                            end
                        end else if (load_use) begin
                            stall_c  = 1'b1;
                            bubble_c = 1'b1;
                        end
                    end
                end else if (wait_cnt_q >= TIMEOUT_LIM) begin
                    timeout_fire = 1'b1;
                    timeout_d    = 1'b1;
                    bubble_c     = 1'b1;
                    resume_d     = 1'b0;
                    wait_cnt_d   = 8'd0;
                    state_d      = ST_RUN;
                end else begin
                    freeze_c   = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_FLUSH: begin
                if (mem_stall) begin
                    freeze_c   = 1'b1;
                    resume_d   = 1'b1;
                    wait_cnt_d = 8'd1;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    flush_c     = 1'b1;
                    bubble_c    = 1'b1;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset holds the pipeline NOPed; freeze overrides every other control.
    assign freeze_all  = reset & freeze_c;
    assign stall_pc    = reset & ~freeze_c & stall_c;
    assign stall_ifid  = reset & ~freeze_c & stall_c;
    assign bubble_ex   = ~reset | (~freeze_c & bubble_c);
    assign flush_ifid  = ~reset | (~freeze_c & flush_c);
    assign mem_timeout = reset & (timeout_q | timeout_fire);

`ifdef PIPELINE_INTERLOCK_PERF_EN
    logic [15:0] load_use_cnt_q, mem_stall_cnt_q, flush_cnt_total_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_use_cnt_q    <= 16'd0;
            mem_stall_cnt_q   <= 16'd0;
            flush_cnt_total_q <= 16'd0;
        end else begin
            if (stall_pc && (load_use_cnt_q != 16'hFFFF)) begin
                load_use_cnt_q <= load_use_cnt_q + 16'd1;
            end
            if (freeze_all && (mem_stall_cnt_q != 16'hFFFF)) begin
                mem_stall_cnt_q <= mem_stall_cnt_q + 16'd1;
            end
            if (flush_ifid && (flush_cnt_total_q != 16'hFFFF)) begin
                flush_cnt_total_q <= flush_cnt_total_q + 16'd1;
            end
        end
    end

    assign load_use_cnt    = load_use_cnt_q;
    assign mem_stall_cnt   = mem_stall_cnt_q;
    assign flush_cnt_total = flush_cnt_total_q;
`endif

endmodule

// File: tb/tb_pipeline_interlock.sv
// Directed + randomized check of pipeline_interlock against a cycle-level behavioural model.
module tb_pipeline_interlock;

    localparam int FC  = 2;
    localparam int TMO = 5;

    logic       clk;
    logic       reset;
    logic [2:0] Rm_id, Rn_id, Rd_ex;
    logic       uses_rm_id, uses_rn_id, write_reg_ex, mem_read_ex;
    logic       branch_taken_ex, mem_req_mem, mem_ready_mem;
    logic       stall_pc, stall_ifid, bubble_ex, flush_ifid, freeze_all, mem_timeout;
`ifdef PIPELINE_INTERLOCK_PERF_EN
    logic [15:0] load_use_cnt, mem_stall_cnt, flush_cnt_total;
`endif

    pipeline_interlock #(.REG_W(3), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .Rm_id(Rm_id), .Rn_id(Rn_id), .uses_rm_id(uses_rm_id), .uses_rn_id(uses_rn_id),
        .Rd_ex(Rd_ex), .write_reg_ex(write_reg_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_ex(branch_taken_ex), .mem_req_mem(mem_req_mem), .mem_ready_mem(mem_ready_mem),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_ex(bubble_ex),
        .flush_ifid(flush_ifid), .freeze_all(freeze_all), .mem_timeout(mem_timeout)
`ifdef PIPELINE_INTERLOCK_PERF_EN
       ,.load_use_cnt(load_use_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt_total(flush_cnt_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: frozen cycles so far, wrong-path bubbles still owed, bubbles parked during a freeze.
    int m_wait       = 0;
    int m_flush_left = 0;
    int m_saved      = 0;
    bit m_to         = 0;
    int c_lu = 0, c_ms = 0, c_fl = 0;

    task automatic drive(input logic rst, input logic [2:0] rm, input logic [2:0] rn,
                         input logic urm, input logic urn, input logic [2:0] rd,
                         input logic wr, input logic mr, input logic br,
                         input logic mq, input logic mrdy, input string tag);
        logic [5:0] exp_v, obs_v;
        bit lu, e_st, e_bub, e_fl, e_fr, fire, eval_run;
        @(negedge clk);
        reset = rst; Rm_id = rm; Rn_id = rn; uses_rm_id = urm; uses_rn_id = urn;
        Rd_ex = rd; write_reg_ex = wr; mem_read_ex = mr; branch_taken_ex = br;
        mem_req_mem = mq; mem_ready_mem = mrdy;
        #1;
        lu = mr && wr && ((urm && rd == rm) || (urn && rd == rn));
        e_st = 0; e_bub = 0; e_fl = 0; e_fr = 0; fire = 0; eval_run = 0;
        if (!rst) begin
            m_wait = 0; m_flush_left = 0; m_saved = 0; m_to = 0;
            c_lu = 0; c_ms = 0; c_fl = 0;
            exp_v = 6'b001100;
        end else begin
            if (m_wait > 0) begin
                if (mrdy) begin
                    m_wait = 0;
                    if (m_saved > 0) begin
                        e_fl = 1; e_bub = 1;
                        m_flush_left = m_saved - 1;
                        m_saved = 0;
                    end else eval_run = 1;
                end else if (m_wait >= TMO) begin
                    fire = 1; e_bub = 1; m_wait = 0; m_saved = 0;
                end else begin
                    e_fr = 1; m_wait++;
                end
            end else if (m_flush_left > 0) begin
                if (mq && !mrdy) begin
                    e_fr = 1; m_saved = m_flush_left; m_flush_left = 0; m_wait = 1;
                end else begin
                    e_fl = 1; e_bub = 1; m_flush_left--;
                end
            end else if (mq && !mrdy) begin
                e_fr = 1; m_wait = 1;
            end else eval_run = 1;
            if (eval_run) begin
                if (br) begin
                    e_fl = 1; e_bub = 1; m_flush_left = FC - 1;
                end else if (lu) begin
                    e_st = 1; e_bub = 1;
                end
            end
            if (fire) m_to = 1;
            c_lu += int'(e_st); c_ms += int'(e_fr); c_fl += int'(e_fl);
            exp_v = {e_st, e_st, e_bub, e_fl, e_fr, m_to};
        end
        obs_v = {stall_pc, stall_ifid, bubble_ex, flush_ifid, freeze_all, mem_timeout};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed {stall_pc,stall_ifid,bubble,flush,freeze,timeout}=%b expected %b",
                   tag, obs_v, exp_v);
        end
    endtask

    task automatic idle(input string tag);
        drive(1, 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        reset = 0; Rm_id = 0; Rn_id = 0; uses_rm_id = 0; uses_rn_id = 0; Rd_ex = 0;
        write_reg_ex = 0; mem_read_ex = 0; branch_taken_ex = 0; mem_req_mem = 0; mem_ready_mem = 0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_hold0");
        drive(0, 3, 0, 1, 0, 3, 1, 1, 1, 1, 0, "reset_hold_busy");
        idle("idle_after_reset");

        drive(1, 3'd3, 3'd5, 1, 0, 3'd3, 1, 1, 0, 0, 0, "load_use_rm");
        idle("load_use_rm_done");
        drive(1, 3'd3, 3'd5, 0, 0, 3'd3, 1, 1, 0, 0, 0, "no_use_rm");
        drive(1, 3'd1, 3'd0, 0, 1, 3'd0, 1, 1, 0, 0, 0, "load_use_rn_r0");
        drive(1, 3'd1, 3'd6, 1, 1, 3'd6, 0, 1, 0, 0, 0, "no_write_no_stall");

        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "branch_c1");
        idle("branch_c2");
        idle("branch_done");

        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "memwait_frozen");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "memwait_ready");
        idle("memwait_done");

        for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "timeout_seq");
        idle("timeout_sticky");

        drive(1, 3'd2, 3'd0, 1, 0, 3'd2, 1, 1, 1, 1, 0, "simul_freeze");
        drive(1, 3'd2, 3'd0, 1, 0, 3'd2, 1, 1, 1, 1, 1, "simul_release_flush");
        idle("simul_flush_tail");
        idle("simul_done");

        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "branch_then_mem");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "flush_interrupted");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "flush_frozen");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "flush_resumed");
        idle("flush_resume_done");

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rst_mid_wait_a");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rst_mid_wait_b");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rst_mid_wait_reset");
        idle("rst_mid_wait_run");
        idle("rst_mid_wait_run2");

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] rd, rm, rn;
            rd = 3'($urandom_range(0, 7));
            rm = ($urandom_range(0, 1) == 0) ? rd : 3'($urandom_range(0, 7));
            rn = ($urandom_range(0, 1) == 0) ? rd : 3'($urandom_range(0, 7));
            drive(logic'($urandom_range(0, 99) != 0), rm, rn,
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), rd,
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 9) < 4), "random");
        end

`ifdef PIPELINE_INTERLOCK_PERF_EN
        @(negedge clk);
        n_cmp++;
        assert ({load_use_cnt, mem_stall_cnt, flush_cnt_total} ===
                {16'(c_lu), 16'(c_ms), 16'(c_fl)}) else begin
            n_fail++;
            $error("FAIL perf_counters: observed %0d/%0d/%0d expected %0d/%0d/%0d",
                   load_use_cnt, mem_stall_cnt, flush_cnt_total, c_lu, c_ms, c_fl);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
